// File: rtl/cam_frame_ctrl_if.sv
// cam_frame_ctrl_if: camera bus, capture control and frame-buffer write signals
interface cam_frame_ctrl_if #(parameter int ADDR_W = 19);
  logic config_done, vsync, href, start, continuous, stop;
  logic [7:0] cam_data;
  logic wr_en, busy, frame_done, frame_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0] wr_data;
  logic [7:0] frame_cnt;
  modport master(
    input config_done, vsync, href, cam_data, start, continuous, stop,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_cnt
  );
  modport slave(
    output config_done, vsync, href, cam_data, start, continuous, stop,
    input wr_en, wr_addr, wr_data, busy, frame_done, frame_err, frame_cnt
  );
endinterface

// File: rtl/cam_frame_ctrl.sv
// cam_frame_ctrl: camera capture sequencer packing byte pairs into RGB565 linear frame-buffer writes
module cam_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W = 19
) (
  input logic pclk,
  input logic reset_n,
  cam_frame_ctrl_if.master bus
);
  // col/row saturate at limit+1 so oversized lines and frames stay detectable
  localparam int CW = $clog2(H_ACTIVE + 2);
  localparam int RW = $clog2(V_ACTIVE + 2);
  localparam logic [CW-1:0] H_L = CW'(H_ACTIVE);
  localparam logic [RW-1:0] V_L = RW'(V_ACTIVE);
  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WAIT_ACTIVE, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [7:0] hi_q, hi_d, cnt_q, cnt_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic phase_q, phase_d, vsync_q, href_q, href_d;
  logic cont_q, cont_d, stop_q, stop_d, ferr_q, ferr_d;
  logic wr_en_q, wr_en_d, done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic err_set;
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      phase_q <= 1'b0;
      vsync_q <= 1'b0;
      href_q <= 1'b0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      ferr_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      addr_q <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      vsync_q <= bus.vsync;
      href_q <= href_d;
      cont_q <= cont_d;
      stop_q <= stop_d;
      ferr_q <= ferr_d;
      wr_en_q <= wr_en_d;
      done_q <= done_d;
      err_q <= err_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    addr_d = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hi_d = hi_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    href_d = bus.href;
    cont_d = cont_q;
    stop_d = stop_q;
    ferr_d = ferr_q;
    wr_en_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: if (bus.start && bus.config_done) begin
        state_d = WAIT_BLANK;
        err_d = 1'b0;
        cont_d = bus.continuous;
        stop_d = 1'b0;
      end
      WAIT_BLANK: if (bus.vsync) state_d = WAIT_ACTIVE;
      WAIT_ACTIVE: if (!bus.vsync) begin
        state_d = CAPTURE;
        col_d = '0;
        row_d = '0;
        addr_d = '0;
        phase_d = 1'b0;
        href_d = 1'b0;
        ferr_d = 1'b0;
      end
      CAPTURE: begin
        if (bus.stop) stop_d = 1'b1;
        if (bus.href) begin
          phase_d = ~phase_q;
          if (!phase_q) hi_d = bus.cam_data;
          else begin
            if (col_q < H_L && row_q < V_L) begin
              wr_en_d = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {hi_q, bus.cam_data};
              addr_d = addr_q + ADDR_W'(1);
            end else err_set = 1'b1;
            if (col_q <= H_L) col_d = col_q + CW'(1);
          end
        end else if (href_q) begin
          if (row_q <= V_L) row_d = row_q + RW'(1);
          col_d = '0;
          phase_d = 1'b0;
          if (phase_q || col_q != H_L) err_set = 1'b1;
        end
        // frame end judged on this cycle's line bookkeeping so a coincident last line counts
        if (bus.vsync && !vsync_q) begin
          if (row_d == V_L && !ferr_q && !err_set) begin
            done_d = 1'b1;
            cnt_d = cnt_q + 8'd1;
          end else err_set = 1'b1;
          state_d = (!cont_q || stop_d) ? IDLE : WAIT_ACTIVE;
        end
      end
    endcase
    if ((state_q == WAIT_BLANK || state_q == WAIT_ACTIVE) && bus.stop) state_d = IDLE;
    if (state_q != IDLE && !bus.config_done) begin
      state_d = IDLE;
      wr_en_d = 1'b0;
      done_d = 1'b0;
      cnt_d = cnt_q;
      err_set = 1'b1;
    end
    ferr_d = ferr_d | err_set;
    err_d = err_d | err_set;
    busy_d = state_d != IDLE;
  end
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy = busy_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_cam_frame_ctrl.sv
// tb_cam_frame_ctrl: directed capture scenarios on a 4x2 frame with hand-computed expectations
module tb_cam_frame_ctrl;
  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int wbase, dbase;
  logic [7:0] bval = 8'd0;
  logic [7:0] b0;
  logic [18:0] addr_log[$];
  logic [15:0] data_log[$];
  cam_frame_ctrl_if #(.ADDR_W(19)) bus();
  cam_frame_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19)) dut(.pclk(pclk), .reset_n(reset_n), .bus(bus));
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (bus.wr_en) begin
      addr_log.push_back(bus.wr_addr);
      data_log.push_back(bus.wr_data);
    end
    if (bus.frame_done) done_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic pulse_start(input logic cont);
    bus.start = 1'b1;
    bus.continuous = cont;
    tick();
    bus.start = 1'b0;
    bus.continuous = 1'b0;
  endtask
  task automatic mark();
    wbase = addr_log.size();
    dbase = done_cnt;
  endtask
  task automatic send_frame(input int extra_line, input int stop_line, input int cfg_line);
    bus.vsync = 1'b1;
    bus.href = 1'b0;
    repeat (2) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < 2; l++) begin
      if (l == cfg_line) bus.config_done = 1'b0;
      if (l == stop_line) begin
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
      end
      for (int b = 0; b < 8 + int'(l == extra_line); b++) begin
        bus.href = 1'b1;
        bus.cam_data = bval;
        bval++;
        tick();
      end
      bus.href = 1'b0;
      repeat (3) tick();
    end
    bus.vsync = 1'b1;
    repeat (3) tick();
  endtask
  initial begin
    bus.config_done = 1'b1;
    bus.vsync = 1'b1;
    bus.href = 1'b0;
    bus.cam_data = 8'd0;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.stop = 1'b0;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_cnt", bus.frame_cnt, 0);
    chk("rst_err", bus.frame_err, 0);
    chk("rst_done", bus.frame_done, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    // snapshot, clean frame, bytes 0x00..0x0F
    mark();
    bval = 8'd0;
    pulse_start(1'b0);
    chk("snap_busy_up", bus.busy, 1);
    send_frame(-1, -1, -1);
    chk("snap_writes", addr_log.size() - wbase, 8);
    for (int k = 0; k < 8; k++) begin
      chk("snap_addr", addr_log[wbase + k], k);
      chk("snap_data", data_log[wbase + k], 16'h0001 + 16'(k) * 16'h0202);
    end
    chk("snap_done", done_cnt - dbase, 1);
    chk("snap_cnt", bus.frame_cnt, 1);
    chk("snap_busy", bus.busy, 0);
    chk("snap_err", bus.frame_err, 0);
    // start in the middle of an active line
    mark();
    bus.vsync = 1'b0;
    for (int b = 0; b < 7; b++) begin
      bus.href = 1'b1;
      bus.cam_data = 8'hA0 + 8'(b);
      bus.start = (b == 2);
      tick();
    end
    bus.start = 1'b0;
    bus.href = 1'b0;
    repeat (3) tick();
    chk("mid_no_write", addr_log.size() - wbase, 0);
    chk("mid_busy", bus.busy, 1);
    b0 = bval;
    send_frame(-1, -1, -1);
    chk("mid_writes", addr_log.size() - wbase, 8);
    chk("mid_addr0", addr_log[wbase], 0);
    chk("mid_data0", data_log[wbase], {b0, b0 + 8'd1});
    chk("mid_done", done_cnt - dbase, 1);
    chk("mid_cnt", bus.frame_cnt, 2);
    // continuous, stop during frame 2
    mark();
    pulse_start(1'b1);
    send_frame(-1, -1, -1);
    chk("cont_busy_f1", bus.busy, 1);
    send_frame(-1, 0, -1);
    chk("cont_writes", addr_log.size() - wbase, 16);
    chk("cont_addr_f2", addr_log[wbase + 15], 7);
    chk("cont_done", done_cnt - dbase, 2);
    chk("cont_cnt", bus.frame_cnt, 4);
    chk("cont_busy", bus.busy, 0);
    mark();
    send_frame(-1, -1, -1);
    chk("cont_f3_writes", addr_log.size() - wbase, 0);
    chk("cont_f3_cnt", bus.frame_cnt, 4);
    // 9-byte first line
    mark();
    pulse_start(1'b0);
    send_frame(0, -1, -1);
    chk("odd_writes", addr_log.size() - wbase, 8);
    chk("odd_addr4", addr_log[wbase + 4], 4);
    chk("odd_addr7", addr_log[wbase + 7], 7);
    chk("odd_err", bus.frame_err, 1);
    chk("odd_done", done_cnt - dbase, 0);
    chk("odd_cnt", bus.frame_cnt, 4);
    pulse_start(1'b0);
    chk("odd_err_clr", bus.frame_err, 0);
    chk("odd_busy", bus.busy, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("wait_stop_busy", bus.busy, 0);
    chk("wait_stop_err", bus.frame_err, 0);
    // config_done drops at row 1
    mark();
    pulse_start(1'b0);
    send_frame(-1, -1, 1);
    chk("cfg_writes", addr_log.size() - wbase, 4);
    chk("cfg_busy", bus.busy, 0);
    chk("cfg_err", bus.frame_err, 1);
    chk("cfg_cnt", bus.frame_cnt, 4);
    chk("cfg_done", done_cnt - dbase, 0);
    bus.config_done = 1'b1;
    // asynchronous reset while a write is on the bus
    pulse_start(1'b0);
    bus.vsync = 1'b1;
    repeat (2) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
    bus.href = 1'b1;
    bus.cam_data = 8'h12;
    tick();
    bus.cam_data = 8'h34;
    tick();
    chk("pre_rst_wr_en", bus.wr_en, 1);
    chk("pre_rst_data", bus.wr_data, 16'h1234);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_data", bus.wr_data, 0);
    chk("arst_cnt", bus.frame_cnt, 0);
    #3 reset_n = 1'b1;
    bus.href = 1'b0;
    bus.config_done = 1'b0;
    tick();
    pulse_start(1'b0);
    tick();
    chk("nocfg_busy", bus.busy, 0);
    chk("nocfg_err", bus.frame_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_frame_ctrl.md
# cam_frame_ctrl

Capture sequencer between the camera pixel bus and the frame buffer. On command it arms and aligns to a frame boundary. It assembles byte pairs into RGB565 pixels and issues linear-address frame-buffer writes for exactly one frame (snapshot) or for every frame until stopped (continuous). It reports completion and malformed frames to the system controller.

## Interface
- H_ACTIVE, 640, pixels per line accepted
- V_ACTIVE, 480, lines per frame accepted
- ADDR_W, 19, frame-buffer address width (must hold H_ACTIVE*V_ACTIVE-1)
- pclk  in  1  camera pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- config_done  in  1  sensor register configuration complete (level)
- vsync  in  1  high during vertical blanking
- href  in  1  high while line bytes are valid
- cam_data  in  8  pixel byte bus
- start  in  1  one-cycle arm request
- continuous  in  1  mode, sampled only on an accepted start: 1 = every frame, 0 = single frame
- stop  in  1  one-cycle request to end continuous capture after the current frame
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  linear pixel address
- wr_data  out  16  {first byte, second byte}
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse per completed good frame
- frame_err  out  1  sticky error flag, cleared by the next accepted start
- frame_cnt  out  8  good frames completed since reset, wraps 255->0

## Operation
- States:
  - IDLE: waits for start.
  - WAIT_BLANK: waits for vsync high.
  - WAIT_ACTIVE: waits for vsync low.
  - CAPTURE: accepts line bytes and issues writes.
- IDLE -> WAIT_BLANK on start with config_done=1. A start with config_done=0 is ignored.
- start is ignored while busy. An accepted start clears frame_err and latches continuous.
- WAIT_BLANK exists so capture never begins mid-frame. If vsync=1 when start is accepted, the block still passes through WAIT_BLANK, which exits one cycle later.
- WAIT_ACTIVE -> CAPTURE on the first cycle with vsync=0. In that cycle col, row, addr and byte phase are cleared.
- CAPTURE, href=1:
  - Phase 0 latches cam_data as the high byte.
  - Phase 1 forms the pixel and writes it if col<H_ACTIVE and row<V_ACTIVE. col and addr then increment.
  - Pixels beyond either limit are dropped and set frame_err.
- CAPTURE, href falling (prev href=1, now 0):
  - row increments and col clears.
  - If the phase is 1, the odd byte is discarded, the phase clears and frame_err is set.
  - If col != H_ACTIVE, frame_err is set.
- CAPTURE, vsync rising ends the frame:
  - Good frame (row==V_ACTIVE and no error this frame): frame_done pulses and frame_cnt increments.
  - Otherwise frame_err is set.
- After frame end:
  - Snapshot, or a stop was seen during this run: go to IDLE.
  - Continuous otherwise: go directly to WAIT_ACTIVE.
- stop outside CAPTURE/WAIT states has no effect. stop in WAIT_BLANK or WAIT_ACTIVE returns to IDLE next cycle with no frame_done.
- config_done falling in any busy state aborts to IDLE next cycle and sets frame_err. No frame_done is issued and partial writes are not retracted.
- Address arithmetic: an incremental counter, no multiplier. wr_addr = row*H_ACTIVE+col by construction, with ADDR_W-bit wrap.

## Timing
- Reset (async assert, sync release): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0, frame_cnt=0; byte phase=0.
- All outputs are registered.
- Second byte of a pixel sampled at edge N: wr_en=1 with the matching wr_addr and wr_data in the cycle after edge N. Latency is 1 pclk.
- wr_en is high for exactly one cycle per pixel. The fastest rate is every other cycle.
- vsync and href edges are detected against a 1-cycle registered copy. The internal previous-href register is cleared on entry to CAPTURE.
- frame_done is asserted the cycle after the vsync-rise edge is detected.
- When frame end and the last pixel write coincide, the write completes first, in the same cycle as or before frame_done.
- busy rises the cycle after an accepted start. It falls the cycle after the transition to IDLE.

## Test plan
- Snapshot, H_ACTIVE=4, V_ACTIVE=2 override, clean frame with bytes 0x00..0x0F -> 8 writes, addr 0..7, data 0x0001,0x0203,...,0x0E0F; one frame_done; frame_cnt=1; busy low afterwards.
- start mid-frame (vsync=0, href active) -> no wr_en until after the next vsync high->low; then exactly one full frame captured.
- Continuous mode over 3 frames, stop pulsed during frame 2 -> frames 1 and 2 written, frame_cnt=2, return to IDLE before frame 3, zero writes in frame 3.
- Line with 9 bytes (H_ACTIVE=4) -> 4 writes on that line, odd byte discarded, frame_err=1, no frame_done; next start clears frame_err.
- config_done deasserted during row 1 -> IDLE next cycle, frame_err=1, no further wr_en, frame_cnt unchanged.
- reset_n pulsed low mid-CAPTURE, asynchronous to pclk -> all outputs 0 immediately; start with config_done=0 afterwards -> stays IDLE.
